// File: rtl/jk_cmd_seq.sv
// JK command sequencer: FIFO of {op,rpt} replayed on registered j/k; first j/k cycle follows the edge after accept.
// cmd_ready drops when the FIFO is full (no pass-through); JK_SEQ_CHECK_EN adds the q_fb shadow checker.
module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [CNT_W-1:0]       cmd_rpt,
    output logic                   j,
    output logic                   k,
    input  logic                   q_fb,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_cnt,
    output logic                   mismatch
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = CNT_W + 2;
    localparam logic [AW:0]      CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      CNT_ONE  = 1;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] REM_ONE  = 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_ISSUE = 1'b1} state_t;

    logic [1:0]       r_sync;
    logic [EW-1:0]    r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [1:0]       r_op;
    logic [1:0]       w_op_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             r_j;
    logic             r_k;
    logic             w_j_nxt;
    logic             w_k_nxt;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [1:0]       w_head_op;
    logic [CNT_W-1:0] w_head_rpt;
    logic [CNT_W-1:0] w_head_len;

    // r_sync[0] opens the input side one edge after release, r_sync[1] lets the FSM start popping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign cmd_ready = r_sync[0] && (r_cnt != CNT_FULL);
    assign w_push    = cmd_valid && cmd_ready;
    assign w_empty   = (r_cnt == '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_rpt};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign {w_head_op, w_head_rpt} = r_mem[r_rd_ptr];
    assign w_head_len = (w_head_rpt == '0) ? REM_ONE : w_head_rpt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_op    <= 2'b00;
            r_rem   <= '0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_rem   <= w_rem_nxt;
            r_j     <= w_j_nxt;
            r_k     <= w_k_nxt;
        end
    end

    // Popping on the last repeat cycle chains commands without a bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sync[1] && !w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_rem == REM_ONE) begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        w_op_nxt  = r_op;
        w_rem_nxt = r_rem;
        if (w_pop) begin
            w_op_nxt  = w_head_op;
            w_rem_nxt = w_head_len;
        end else if (r_state == ST_ISSUE) begin
            w_rem_nxt = r_rem - REM_ONE;
        end
        w_j_nxt = (w_state_nxt == ST_ISSUE) && w_op_nxt[1];
        w_k_nxt = (w_state_nxt == ST_ISSUE) && w_op_nxt[0];
    end

    assign j        = r_j;
    assign k        = r_k;
    assign busy     = (r_state == ST_ISSUE) || !w_empty;
    assign fifo_cnt = r_cnt;

`ifdef JK_SEQ_CHECK_EN
    logic r_exp_q;
    logic r_chk_vld;
    logic r_mismatch;

    // The flip-flop samples j/k on the edge ending each ISSUE cycle; its q is compared in the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_exp_q    <= 1'b0;
            r_chk_vld  <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_chk_vld <= (r_state == ST_ISSUE);
            if (r_state == ST_ISSUE) begin
                case (r_op)
                    2'b01:   r_exp_q <= 1'b0;
                    2'b10:   r_exp_q <= 1'b1;
                    2'b11:   r_exp_q <= ~r_exp_q;
                    default: r_exp_q <= r_exp_q;
                endcase
            end
            if (r_chk_vld && (q_fb != r_exp_q)) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign mismatch = r_mismatch;
`else
    logic w_unused_q_fb;
    assign w_unused_q_fb = q_fb;
    assign mismatch      = 1'b0;
`endif

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Scoreboard bench for jk_cmd_seq: drives commands, models the downstream JK flip-flop on q_fb.
`timescale 1ns/1ps
module tb_jk_cmd_seq;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
`ifdef JK_SEQ_CHECK_EN
    localparam logic EXP_MM = 1'b1;
`else
    localparam logic EXP_MM = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_rpt = '0;
    logic             j;
    logic             k;
    logic             q_fb;
    logic             busy;
    logic [$clog2(DEPTH):0] fifo_cnt;
    logic             mismatch;

    logic             r_q;
    logic             force_q0 = 1'b0;
    logic [1:0]       sb [$];
    int               n_checks = 0;
    int               n_errors = 0;

    jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rpt(cmd_rpt), .j(j), .k(k), .q_fb(q_fb),
        .busy(busy), .fifo_cnt(fifo_cnt), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    // Downstream JK flip-flop; force_q0 models a stuck-at-0 output.
    always @(posedge clk or negedge rst) begin
        if (!rst) r_q <= 1'b0;
        else case ({j, k})
            2'b01:   r_q <= 1'b0;
            2'b10:   r_q <= 1'b1;
            2'b11:   r_q <= ~r_q;
            default: r_q <= r_q;
        endcase
    end
    assign q_fb = force_q0 ? 1'b0 : r_q;

    // Every non-hold j/k cycle must match the next scoreboard entry.
    always @(negedge clk) begin : mon
        logic [1:0] e;
        if (rst && (j || k)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: jk=%b seen, required no output", {j, k});
            end else begin
                e = sb.pop_front();
                if ({j, k} !== e) begin
                    n_errors++;
                    $display("FAIL sb_jk: got %b required %b at %0t", {j, k}, e, $time);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [CNT_W-1:0] rpt, output int waited);
        int n = 0;
        int len;
        cmd_valid = 1'b1; cmd_op = op; cmd_rpt = rpt;
        while (!cmd_ready && n < 200) begin cyc(); n++; end
        waited = n;
        if (!cmd_ready) begin
            n_checks++; n_errors++;
            $display("FAIL push_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end else begin
            len = (rpt == '0) ? 1 : int'(rpt);
            if (op != 2'b00) for (int i = 0; i < len; i++) sb.push_back(op);
            cyc();
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin cyc(); n++; end
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL %s_idle: busy=%b required 0", name, busy); end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rst_ready: got %b required 0", cmd_ready); end
        n_checks++; if ({j, k} !== 2'b00) begin n_errors++; $display("FAIL rst_jk: got %b required 00", {j, k}); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_checks++; if (fifo_cnt !== '0) begin n_errors++; $display("FAIL rst_cnt: got %0d required 0", fifo_cnt); end
        n_checks++; if (mismatch !== 1'b0) begin n_errors++; $display("FAIL rst_mm: got %b required 0", mismatch); end
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL rel_ready_early: got %b required 0", cmd_ready); end
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_errors++; $display("FAIL rel_ready: got %b required 1", cmd_ready); end
        repeat (2) cyc();
    endtask

    task automatic test_single();
        int w;
        push(2'b10, 4'd0, w);
        @(negedge clk);
        n_checks++; if ({j, k, busy} !== 3'b001) begin n_errors++; $display("FAIL single_lat: got jk/busy=%b required 001", {j, k, busy}); end
        n_checks++; if (fifo_cnt !== 1) begin n_errors++; $display("FAIL single_cnt: got %0d required 1", fifo_cnt); end
        @(negedge clk);
        n_checks++; if ({j, k} !== 2'b10) begin n_errors++; $display("FAIL single_jk: got %b required 10", {j, k}); end
        @(negedge clk);
        n_checks++; if ({j, k, busy} !== 3'b000) begin n_errors++; $display("FAIL single_end: got jk/busy=%b required 000", {j, k, busy}); end
        n_checks++; if (mismatch !== 1'b0) begin n_errors++; $display("FAIL single_mm: got %b required 0", mismatch); end
    endtask

    task automatic test_back_to_back();
        int w;
        logic [1:0] tr [6];
        tr = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01, 2'b00};
        push(2'b11, 4'd3, w);
        push(2'b01, 4'd2, w);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if ({j, k} !== tr[i]) begin n_errors++; $display("FAIL b2b_trace[%0d]: got %b required %b", i, {j, k}, tr[i]); end
        end
        wait_idle("b2b");
    endtask

    task automatic test_hold();
        int w;
        push(2'b00, 4'd2, w);
        push(2'b10, 4'd1, w);
        @(negedge clk);
        n_checks++; if ({j, k, busy} !== 3'b001) begin n_errors++; $display("FAIL hold_c0: got jk/busy=%b required 001", {j, k, busy}); end
        @(negedge clk);
        n_checks++; if ({j, k, busy} !== 3'b001) begin n_errors++; $display("FAIL hold_c1: got jk/busy=%b required 001", {j, k, busy}); end
        @(negedge clk);
        n_checks++; if ({j, k} !== 2'b10) begin n_errors++; $display("FAIL hold_set: got %b required 10", {j, k}); end
        wait_idle("hold");
    endtask

    task automatic test_full();
        int w;
        push(2'b11, 4'd15, w);
        push(2'b10, 4'd1, w);
        push(2'b01, 4'd1, w);
        push(2'b11, 4'd2, w);
        push(2'b10, 4'd3, w);
        @(negedge clk);
        n_checks++; if (fifo_cnt !== 4) begin n_errors++; $display("FAIL full_cnt: got %0d required 4", fifo_cnt); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b required 0", cmd_ready); end
        push(2'b01, 4'd2, w);
        n_checks++; if (w !== 12) begin n_errors++; $display("FAIL full_wait: got %0d cycles required 12", w); end
        wait_idle("full");
        n_checks++; if (sb.size() !== 0) begin n_errors++; $display("FAIL full_lost: %0d entries left, required 0", sb.size()); end
        n_checks++; if (fifo_cnt !== 0) begin n_errors++; $display("FAIL full_drain: got %0d required 0", fifo_cnt); end
    endtask

    task automatic test_checker();
        int w;
        repeat (2) cyc();
        force_q0 = 1'b1;
        push(2'b10, 4'd1, w);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if ({j, k, mismatch} !== 3'b100) begin n_errors++; $display("FAIL chk_issue: got jk/mm=%b required 100", {j, k, mismatch}); end
        @(negedge clk);
        n_checks++; if (mismatch !== 1'b0) begin n_errors++; $display("FAIL chk_early: got %b required 0", mismatch); end
        @(negedge clk);
        n_checks++; if (mismatch !== EXP_MM) begin n_errors++; $display("FAIL chk_flag: got %b required %b", mismatch, EXP_MM); end
        force_q0 = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (mismatch !== EXP_MM) begin n_errors++; $display("FAIL chk_sticky: got %b required %b", mismatch, EXP_MM); end
    endtask

    task automatic test_reset_mid();
        int w;
        int pulses = 0;
        rst = 1'b0; repeat (2) cyc(); rst = 1'b1; repeat (3) cyc();
        n_checks++; if (mismatch !== 1'b0) begin n_errors++; $display("FAIL mid_mm_clr: got %b required 0", mismatch); end
        push(2'b11, 4'd8, w);
        push(2'b10, 4'd2, w);
        push(2'b01, 4'd1, w);
        cyc();
        #2 rst = 1'b0;
        #1;
        n_checks++; if ({j, k} !== 2'b00) begin n_errors++; $display("FAIL mid_jk: got %b required 00", {j, k}); end
        n_checks++; if (fifo_cnt !== 0) begin n_errors++; $display("FAIL mid_cnt: got %0d required 0", fifo_cnt); end
        n_checks++; if ({busy, cmd_ready} !== 2'b00) begin n_errors++; $display("FAIL mid_busy_rdy: got %b required 00", {busy, cmd_ready}); end
        sb.delete();
        repeat (2) cyc();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (j || k) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL mid_pulse: got %0d pulses required 0", pulses); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_busy_after: got %b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_full();
        test_checker();
        test_reset_mid();
        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
endmodule
